// File: rtl/bms_contactor_sequencer.sv
// BMS contactor sequencer: precharge, close and open sequencing of the
// pack contactors with debounced SOA fault handling, retries and lockout.
module bms_contactor_sequencer #(
    parameter int unsigned DEBOUNCE_CYC   = 4,
    parameter int unsigned PRECHG_TIMEOUT = 1000,
    parameter int unsigned CLOSE_OVERLAP  = 8,
    parameter int unsigned OPEN_DELAY     = 8,
    parameter int unsigned COOLDOWN_CYC   = 100,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_req,
    input  logic       soa_violation,
    input  logic       precharge_done,
    input  logic       fault_clear,
    output logic       precharge_en,
    output logic       main_neg_en,
    output logic       main_pos_en,
    output logic       fault_latched,
    output logic       ready,
    output logic [2:0] state_code,
    output logic [1:0] retry_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRECHARGE = 3'd1,
        S_CLOSE     = 3'd2,
        S_RUN       = 3'd3,
        S_OPENING   = 3'd4,
        S_FAULT     = 3'd5,
        S_COOLDOWN  = 3'd6,
        S_LOCKOUT   = 3'd7
    } state_t;

    // Counters hold (cycles already spent - 1) on the deciding edge.
    localparam logic [15:0] L_DEB = 16'(DEBOUNCE_CYC - 1);
    localparam logic [15:0] L_PTO = 16'(PRECHG_TIMEOUT - 1);
    localparam logic [15:0] L_CLO = 16'(CLOSE_OVERLAP - 1);
    localparam logic [15:0] L_OPN = 16'(OPEN_DELAY - 1);
    localparam logic [15:0] L_CDN = 16'(COOLDOWN_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [15:0] r_deb;
    logic [1:0]  r_retry;
    logic        r_fault;
    logic        r_prechg;
    logic        r_neg;
    logic        r_pos;
    logic        r_ready;
    logic        w_active;
    logic        w_trip;
    logic        w_lock;
    logic        w_enter_fault;
    logic        w_enter_cool;
    logic        w_cnt_clr;

    always_comb begin
        w_active = (r_state == S_PRECHARGE) || (r_state == S_CLOSE) ||
                   (r_state == S_RUN) || (r_state == S_OPENING);
        w_trip   = w_active && soa_violation && (r_deb == L_DEB);
        w_lock   = 32'(r_retry) >= MAX_RETRIES;
        w_next   = r_state;
        unique case (r_state)
            S_IDLE:
                if (enable_req && !soa_violation) w_next = S_PRECHARGE;
            S_PRECHARGE:
                if (precharge_done)     w_next = S_CLOSE;
                else if (r_cnt == L_PTO) w_next = S_FAULT;
            S_CLOSE:
                if (r_cnt == L_CLO) w_next = S_RUN;
            S_RUN:
                if (!enable_req) w_next = S_OPENING;
            S_OPENING:
                if (r_cnt == L_OPN) w_next = S_IDLE;
            S_FAULT:
                if (w_lock) w_next = S_LOCKOUT;
                else if (fault_clear && !soa_violation) w_next = S_COOLDOWN;
            S_COOLDOWN:
                if (!soa_violation && r_cnt == L_CDN) w_next = S_IDLE;
            S_LOCKOUT:
                w_next = S_LOCKOUT;
            default:
                w_next = S_IDLE;
        endcase
        // A debounced trip overrides any other move this cycle.
        if (w_trip) w_next = S_FAULT;
        w_enter_fault = (w_next == S_FAULT) && (r_state != S_FAULT);
        w_enter_cool  = (w_next == S_COOLDOWN) && (r_state != S_COOLDOWN);
        w_cnt_clr     = (w_next != r_state) ||
                        ((r_state == S_COOLDOWN) && soa_violation);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_deb    <= '0;
            r_retry  <= '0;
            r_fault  <= 1'b0;
            r_prechg <= 1'b0;
            r_neg    <= 1'b0;
            r_pos    <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_clr ? '0 : r_cnt + 16'd1;
            r_deb   <= (w_active && soa_violation && !w_trip) ?
                       r_deb + 16'd1 : '0;
            if (w_enter_fault) begin
                r_fault <= 1'b1;
                if (r_retry != 2'd3) r_retry <= r_retry + 2'd1;
            end else if (w_enter_cool) begin
                r_fault <= 1'b0;
            end
            // Drives decode the next state so they move with it.
            r_prechg <= (w_next == S_PRECHARGE) || (w_next == S_CLOSE);
            r_neg    <= (w_next == S_PRECHARGE) || (w_next == S_CLOSE) ||
                        (w_next == S_RUN) || (w_next == S_OPENING);
            r_pos    <= (w_next == S_CLOSE) || (w_next == S_RUN);
            r_ready  <= (w_next == S_RUN);
        end
    end

    assign precharge_en  = r_prechg;
    assign main_neg_en   = r_neg;
    assign main_pos_en   = r_pos;
    assign fault_latched = r_fault;
    assign ready         = r_ready;
    assign state_code    = r_state;
    assign retry_count   = r_retry;

endmodule

// File: tb/tb_bms_contactor_sequencer.sv
// Bench for bms_contactor_sequencer: directed scenarios plus random
// stimulus tracked against a cycle-level behavioural model.
module tb_bms_contactor_sequencer;

    localparam int DEB = 4;
    localparam int PTO = 1000;
    localparam int COV = 8;
    localparam int ODL = 8;
    localparam int CDC = 100;
    localparam int MXR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable_req;
    logic       soa_violation;
    logic       precharge_done;
    logic       fault_clear;
    logic       precharge_en;
    logic       main_neg_en;
    logic       main_pos_en;
    logic       fault_latched;
    logic       ready;
    logic [2:0] state_code;
    logic [1:0] retry_count;

    int n_chk  = 0;
    int n_fail = 0;

    bms_contactor_sequencer #(
        .DEBOUNCE_CYC  (DEB),
        .PRECHG_TIMEOUT(PTO),
        .CLOSE_OVERLAP (COV),
        .OPEN_DELAY    (ODL),
        .COOLDOWN_CYC  (CDC),
        .MAX_RETRIES   (MXR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_req    (enable_req),
        .soa_violation (soa_violation),
        .precharge_done(precharge_done),
        .fault_clear   (fault_clear),
        .precharge_en  (precharge_en),
        .main_neg_en   (main_neg_en),
        .main_pos_en   (main_pos_en),
        .fault_latched (fault_latched),
        .ready         (ready),
        .state_code    (state_code),
        .retry_count   (retry_count)
    );

    always #5 clk = ~clk;

    wire [9:0] w_obs = {precharge_en, main_neg_en, main_pos_en, ready,
                        fault_latched, state_code, retry_count};

    // Reference: which pack phase we are in, how long it has lasted,
    // how long the current SOA violation has persisted, fault history.
    typedef struct packed {
        int code;
        int spent;
        int streak;
        int retry;
        bit latch;
    } mdl_t;

    mdl_t m = '0;

    function automatic mdl_t mstep(mdl_t c, bit en, bit soa,
                                   bit pd, bit fc);
        mdl_t n;
        int   nc;
        bit   live;
        n    = c;
        nc   = c.code;
        live = (c.code >= 1) && (c.code <= 4);
        case (c.code)
            0: if (en && !soa) nc = 1;
            1: if (pd) nc = 2;
               else if (c.spent + 1 == PTO) nc = 5;
            2: if (c.spent + 1 == COV) nc = 3;
            3: if (!en) nc = 4;
            4: if (c.spent + 1 == ODL) nc = 0;
            5: if (c.retry == MXR) nc = 7;
               else if (fc && !soa) nc = 6;
            6: if (!soa && c.spent + 1 == CDC) nc = 0;
            default: nc = 7;
        endcase
        n.streak = (live && soa) ? c.streak + 1 : 0;
        if (n.streak == DEB) begin
            nc       = 5;
            n.streak = 0;
        end
        if (nc == 5 && c.code != 5) begin
            n.latch = 1'b1;
            if (n.retry < 3) n.retry = n.retry + 1;
        end
        if (nc == 6 && c.code != 6) n.latch = 1'b0;
        if (nc != c.code || (nc == 6 && soa)) n.spent = 0;
        else n.spent = c.spent + 1;
        n.code = nc;
        return n;
    endfunction

    function automatic logic [9:0] exp_vec(mdl_t c);
        bit pc, ng, ps, rd;
        pc = (c.code == 1) || (c.code == 2);
        ng = (c.code >= 1) && (c.code <= 4);
        ps = (c.code == 2) || (c.code == 3);
        rd = (c.code == 3);
        return {pc, ng, ps, rd, c.latch, 3'(c.code), 2'(c.retry)};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) m <= '0;
        else m <= mstep(m, enable_req, soa_violation,
                        precharge_done, fault_clear);
    end

    always @(negedge clk) begin
        n_chk++;
        if (w_obs !== exp_vec(m)) begin
            n_fail++;
            $display("FAIL model_track t=%0t: got %b want %b",
                     $time, w_obs, exp_vec(m));
        end
        n_chk++;
        if (main_pos_en === 1'b1 && main_neg_en !== 1'b1) begin
            n_fail++;
            $display("FAIL pos_without_neg t=%0t: pos=%b neg=%b want neg=1",
                     $time, main_pos_en, main_neg_en);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_code(input logic [2:0] code, input int budget,
                             output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (state_code === code) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        enable_req = 1'b0;
        soa_violation = 1'b0;
        precharge_done = 1'b0;
        fault_clear = 1'b0;
        cyc(2);
        n_chk++;
        if (w_obs !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", w_obs, 10'd0);
        end
        rst_n = 1'b1;
        cyc(2);
        n_chk++;
        if (state_code !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got %0d want 0", state_code);
        end
    endtask

    task automatic test_nominal;
        enable_req = 1'b1;
        cyc(1);
        n_chk++;
        if ({state_code, precharge_en, main_neg_en, main_pos_en}
            !== {3'd1, 3'b110}) begin
            n_fail++;
            $display("FAIL nom_precharge: got %0d/%b%b%b want 1/110",
                     state_code, precharge_en, main_neg_en, main_pos_en);
        end
        cyc(19);
        precharge_done = 1'b1;
        cyc(1);
        precharge_done = 1'b0;
        n_chk++;
        if ({state_code, precharge_en, main_neg_en, main_pos_en}
            !== {3'd2, 3'b111}) begin
            n_fail++;
            $display("FAIL nom_close: got %0d/%b%b%b want 2/111",
                     state_code, precharge_en, main_neg_en, main_pos_en);
        end
        cyc(COV - 1);
        n_chk++;
        if (state_code !== 3'd2) begin
            n_fail++;
            $display("FAIL nom_close_len: got %0d want 2", state_code);
        end
        cyc(1);
        n_chk++;
        if ({state_code, ready, precharge_en} !== {3'd3, 2'b10}) begin
            n_fail++;
            $display("FAIL nom_run: got %0d rdy=%b pc=%b want 3 rdy=1 pc=0",
                     state_code, ready, precharge_en);
        end
        enable_req = 1'b0;
        cyc(1);
        n_chk++;
        if ({state_code, main_neg_en, main_pos_en} !== {3'd4, 2'b10}) begin
            n_fail++;
            $display("FAIL nom_opening: got %0d/%b%b want 4/10",
                     state_code, main_neg_en, main_pos_en);
        end
        enable_req = 1'b1;
        cyc(ODL - 1);
        n_chk++;
        if ({state_code, main_neg_en} !== {3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL nom_open_len: got %0d/%b want 4/1",
                     state_code, main_neg_en);
        end
        enable_req = 1'b0;
        cyc(1);
        n_chk++;
        if ({state_code, main_neg_en} !== {3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL nom_idle: got %0d/%b want 0/0",
                     state_code, main_neg_en);
        end
    endtask

    task automatic test_debounce;
        bit ok;
        enable_req = 1'b1;
        precharge_done = 1'b1;
        wait_code(3'd3, 30, ok);
        precharge_done = 1'b0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL deb_reach_run: got %0d want 3", state_code);
        end
        repeat (2) begin
            soa_violation = 1'b1;
            cyc(DEB - 1);
            soa_violation = 1'b0;
            cyc(1);
        end
        n_chk++;
        if ({state_code, fault_latched} !== {3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL deb_short_pulse: got %0d/%b want 3/0",
                     state_code, fault_latched);
        end
        soa_violation = 1'b1;
        cyc(DEB - 1);
        n_chk++;
        if (state_code !== 3'd3) begin
            n_fail++;
            $display("FAIL deb_pre_trip: got %0d want 3", state_code);
        end
        cyc(1);
        n_chk++;
        if ({state_code, precharge_en, main_neg_en, main_pos_en,
             retry_count, fault_latched} !== {3'd5, 3'b000, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL deb_trip: got %0d/%b%b%b r=%0d f=%b want 5/000 r=1 f=1",
                     state_code, precharge_en, main_neg_en, main_pos_en,
                     retry_count, fault_latched);
        end
    endtask

    task automatic test_recovery;
        enable_req = 1'b0;
        fault_clear = 1'b1;
        soa_violation = 1'b1;
        cyc(3);
        n_chk++;
        if ({state_code, fault_latched} !== {3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL rec_hold_fault: got %0d/%b want 5/1",
                     state_code, fault_latched);
        end
        soa_violation = 1'b0;
        cyc(1);
        fault_clear = 1'b0;
        n_chk++;
        if ({state_code, fault_latched} !== {3'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL rec_cooldown: got %0d/%b want 6/0",
                     state_code, fault_latched);
        end
        cyc(50);
        soa_violation = 1'b1;
        cyc(1);
        soa_violation = 1'b0;
        cyc(CDC - 1);
        n_chk++;
        if (state_code !== 3'd6) begin
            n_fail++;
            $display("FAIL rec_restart: got %0d want 6", state_code);
        end
        cyc(1);
        n_chk++;
        if (state_code !== 3'd0) begin
            n_fail++;
            $display("FAIL rec_idle: got %0d want 0", state_code);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        enable_req = 1'b1;
        cyc(1);
        cyc(PTO - 1);
        n_chk++;
        if (state_code !== 3'd1) begin
            n_fail++;
            $display("FAIL pto_before: got %0d want 1", state_code);
        end
        cyc(1);
        n_chk++;
        if ({state_code, fault_latched, retry_count, main_neg_en,
             precharge_en} !== {3'd5, 1'b1, 2'd2, 2'b00}) begin
            n_fail++;
            $display("FAIL pto_fault: got %0d f=%b r=%0d n=%b p=%b want 5 1 2 0 0",
                     state_code, fault_latched, retry_count,
                     main_neg_en, precharge_en);
        end
        enable_req = 1'b0;
        fault_clear = 1'b1;
        cyc(1);
        fault_clear = 1'b0;
        wait_code(3'd0, CDC + 20, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL pto_recover: got %0d want 0", state_code);
        end
    endtask

    task automatic test_lockout;
        bit ok;
        enable_req = 1'b1;
        precharge_done = 1'b1;
        wait_code(3'd3, 30, ok);
        precharge_done = 1'b0;
        soa_violation = 1'b1;
        cyc(DEB);
        soa_violation = 1'b0;
        n_chk++;
        if ({ok, state_code, retry_count} !== {1'b1, 3'd5, 2'd3}) begin
            n_fail++;
            $display("FAIL lock_third_fault: got ok=%b %0d r=%0d want 1 5 3",
                     ok, state_code, retry_count);
        end
        fault_clear = 1'b1;
        cyc(1);
        n_chk++;
        if ({state_code, fault_latched, main_neg_en} !== {3'd7, 2'b10}) begin
            n_fail++;
            $display("FAIL lock_enter: got %0d/%b/%b want 7/1/0",
                     state_code, fault_latched, main_neg_en);
        end
        cyc(10);
        n_chk++;
        if ({state_code, fault_latched} !== {3'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL lock_hold: got %0d/%b want 7/1",
                     state_code, fault_latched);
        end
        rst_n = 1'b0;
        fault_clear = 1'b0;
        enable_req = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        n_chk++;
        if (w_obs !== 10'd0) begin
            n_fail++;
            $display("FAIL lock_reset: got %b want %b", w_obs, 10'd0);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        enable_req = 1'b1;
        precharge_done = 1'b1;
        wait_code(3'd2, 10, ok);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        n_chk++;
        if ({ok, w_obs} !== {1'b1, 10'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: got ok=%b %b want 1 %b",
                     ok, w_obs, 10'd0);
        end
        precharge_done = 1'b0;
        soa_violation = 1'b1;
        cyc(5);
        n_chk++;
        if (state_code !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_soa_block: got %0d want 0", state_code);
        end
        soa_violation = 1'b0;
        cyc(1);
        n_chk++;
        if (state_code !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_soa_release: got %0d want 1", state_code);
        end
        enable_req = 1'b0;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    task automatic test_random(input int ncyc, input int soa_odds);
        int burst;
        burst = 0;
        for (int i = 0; i < ncyc; i++) begin
            enable_req     = ($urandom_range(0, 9) != 0);
            precharge_done = ($urandom_range(0, 15) == 0);
            fault_clear    = ($urandom_range(0, 3) == 0);
            rst_n          = ($urandom_range(0, 599) != 0);
            if (burst > 0) begin
                soa_violation = 1'b1;
                burst--;
            end else if ($urandom_range(0, soa_odds - 1) == 0) begin
                soa_violation = 1'b1;
                burst = int'($urandom_range(0, 5));
            end else begin
                soa_violation = 1'b0;
            end
            cyc(1);
        end
        rst_n = 1'b1;
        soa_violation = 1'b0;
        n_chk++;
        if (w_obs !== exp_vec(m)) begin
            n_fail++;
            $display("FAIL rand_final: got %b want %b", w_obs, exp_vec(m));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_debounce();
        test_recovery();
        test_timeout();
        test_lockout();
        test_reset_mid();
        test_random(2500, 150);
        test_random(1500, 12);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bms_contactor_sequencer.md
BMS_CONTACTOR_SEQUENCER -- requirements
Module: bms_contactor_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEBOUNCE_CYC, 4, consecutive soa_violation samples that trip a fault.
- PRECHG_TIMEOUT, 1000, maximum PRECHARGE cycles before a fault.
- CLOSE_OVERLAP, 8, cycles precharge and main_pos are both closed.
- OPEN_DELAY, 8, cycles between main_pos open and main_neg open.
- COOLDOWN_CYC, 100, cycles spent in COOLDOWN after fault_clear.
- MAX_RETRIES, 3, fault count that forces LOCKOUT.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low.
- enable_req, in, 1, host request to energise the pack.
- soa_violation, in, 1, active-high SOA violation flag from the protection monitor.
- precharge_done, in, 1, bus voltage within precharge window.
- fault_clear, in, 1, host fault acknowledge.
- precharge_en, out, 1, precharge contactor drive.
- main_neg_en, out, 1, negative main contactor drive.
- main_pos_en, out, 1, positive main contactor drive.
- fault_latched, out, 1, a fault is held.
- ready, out, 1, pack connected (RUN).
- state_code, out, 3, current state.
- retry_count, out, 2, faults since reset, saturating.

Function
REQ-003 The FSM SHALL have eight states, with state_code encodings IDLE=0, PRECHARGE=1, CLOSE=2, RUN=3, OPENING=4, FAULT=5, COOLDOWN=6, LOCKOUT=7.
REQ-004 All outputs SHALL be registered Moore decodes of the state that update on the same clk edge that samples the triggering input.
REQ-005 The output map SHALL be:
- PRECHARGE: neg=1, prechg=1.
- CLOSE: neg=1, prechg=1, pos=1.
- RUN: neg=1, pos=1, ready=1.
- OPENING: neg=1 only.
- All other states: all contactor drives 0.
REQ-006 IDLE->PRECHARGE SHALL occur when enable_req=1 and soa_violation=0; enable_req SHALL be ignored while soa_violation=1.
REQ-007 PRECHARGE->CLOSE SHALL occur when precharge_done=1.
REQ-008 PRECHARGE->FAULT SHALL occur when the cycle counter reaches PRECHG_TIMEOUT without precharge_done; if precharge_done=1 on the timeout cycle, CLOSE SHALL win.
REQ-009 CLOSE->RUN SHALL occur after exactly CLOSE_OVERLAP cycles in CLOSE.
REQ-010 RUN->OPENING SHALL occur when enable_req=0.
REQ-011 OPENING->IDLE SHALL occur after exactly OPEN_DELAY cycles; enable_req returning to 1 during OPENING SHALL NOT abort the opening.
REQ-012 Debounce counter behaviour:
- counts consecutive soa_violation=1 samples in PRECHARGE, CLOSE, RUN and OPENING;
- clears on any 0 sample or any other state;
- at count==DEBOUNCE_CYC the FSM SHALL go to FAULT, and all contactors SHALL open on that same edge.
REQ-013 A debounce fault SHALL take priority over every other transition in the same cycle.
REQ-014 Each entry to FAULT SHALL increment retry_count, saturating at 3, and SHALL set fault_latched=1.
REQ-015 FAULT->LOCKOUT SHALL occur on the cycle after entry if retry_count==MAX_RETRIES.
REQ-016 Otherwise FAULT->COOLDOWN SHALL occur when fault_clear=1 and soa_violation=0.
REQ-017 fault_latched SHALL clear on entry to COOLDOWN.
REQ-018 COOLDOWN->IDLE SHALL occur after exactly COOLDOWN_CYC cycles; soa_violation=1 during COOLDOWN SHALL restart the count.
REQ-019 LOCKOUT SHALL be exited only by reset; fault_latched SHALL stay 1 and all drives SHALL stay 0.
REQ-020 Cycle counters SHALL be 16 bits and SHALL reload to 0 on every state change.
REQ-021 main_pos_en=1 SHALL never occur while main_neg_en=0.

Reset
REQ-022 When rst_n=0 at a clk edge, including mid-sequence, the block SHALL enter IDLE and drive all outputs to 0, with retry_count=0 and all counters=0.
REQ-023 Contactor drives SHALL be 0 on the first edge with rst_n=0.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Nominal sequence: enable_req=1; precharge_done=1 at cycle 20 -> CLOSE for 8 cycles -> RUN with ready=1; enable_req=0 -> pos=0, then neg=0 after 8 cycles -> IDLE.
- Debounce: in RUN, soa_violation pulses of 3 cycles -> no fault. A 4-cycle pulse -> FAULT with all drives 0 on the 4th sampled edge and retry_count=1.
- Precharge timeout: precharge_done held 0 -> FAULT after 1000 cycles with fault_latched=1.
- Recovery: in FAULT, fault_clear=1 while soa_violation=1 -> stays FAULT; soa_violation=0 -> COOLDOWN; IDLE after 100 cycles.
- Lockout: third fault -> LOCKOUT (state_code=7); fault_clear is ignored; rst_n=0 -> IDLE with retry_count=0.
- Reset mid-sequence: rst_n=0 in CLOSE -> all drives 0 on the next edge; soa_violation=1 in IDLE with enable_req=1 -> remains IDLE.
